// File: rtl/ib_pkg.sv
// Shared types and bit positions for the host/MCU link controller.
package ib_pkg;

  // Port-expander bus operation codes used by the port-register emulator.
  typedef enum logic [1:0] {
    READ,
    WRITE,
    OP_OR,
    OP_AND
  } busOp;

  // Link handshake states.
  typedef enum logic [2:0] {
    StIdle,
    StRdPresent,
    StRdRelease,
    StWrWait,
    StWrPush,
    StWrAck
  } link_state_t;

  // p7 (MCU-written control) bit positions.
  localparam int unsigned P7_MODE  = 0;  // 0 = read (host->MCU), 1 = write (MCU->host)
  localparam int unsigned P7_RDC_N = 1;  // read_complete_n
  localparam int unsigned P7_WRA_N = 2;  // write_available_n
  localparam int unsigned P7_EN    = 3;  // 0 = flush

  // p6 (status returned to MCU) bit positions.
  localparam int unsigned P6_RDA_N  = 0;  // rd_avail_n
  localparam int unsigned P6_FULL   = 1;  // RX FIFO full
  localparam int unsigned P6_TMO    = 2;  // sticky handshake timeout
  localparam int unsigned P6_WACK_N = 3;  // wr_ack_n

  // Assemble the p6 nibble from its individual flags.
  function automatic logic [3:0] pack_p6(input logic rda_n, input logic full,
                                         input logic tmo, input logic wack_n);
    logic [3:0] v;
    v            = '0;
    v[P6_RDA_N]  = rda_n;
    v[P6_FULL]   = full;
    v[P6_TMO]    = tmo;
    v[P6_WACK_N] = wack_n;
    return v;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with first-word fall-through read data and synchronous flush.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wr_data,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped; a pop from an empty one is ignored.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/mcu_link_ctrl.sv
// Host UART <-> OKI MCU nibble-port byte transfer controller.
// Buffers host bytes for MCU reads and forwards MCU writes to the UART transmitter.
module mcu_link_ctrl
  import ib_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 800000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [3:0] p7_ctrl,
  input  logic [7:0] mcu_wr_data,
  output logic [7:0] host_rd_data,
  output logic [3:0] p6_status
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // FIFO interface
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic [7:0]    fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // FSM and handshake state
  link_state_t   state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_counting;
  logic          tmo_hit;
  logic          latch_wr;
  logic [7:0]    host_rd_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          rda_n_q;
  logic          tmo_q;
  logic          wack_n_q;

  logic p7_mode;
  logic p7_rdc_n;
  logic p7_wra_n;
  logic p7_en;

  assign p7_mode  = p7_ctrl[P7_MODE];
  assign p7_rdc_n = p7_ctrl[P7_RDC_N];
  assign p7_wra_n = p7_ctrl[P7_WRA_N];
  assign p7_en    = p7_ctrl[P7_EN];

  // The FIFO takes host bytes regardless of the handshake state.
  assign rx_ready  = (fifo_count != FIFO_FULL_CNT);
  assign fifo_push = rx_valid & rx_ready;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wr_data (rx_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Only the states that wait on the MCU can time out.
  assign tmo_counting = (state_q == StRdPresent) || (state_q == StRdRelease) ||
                        (state_q == StWrAck);

  // Next-state logic: flush first (deferred while a byte is mid-push), then timeout,
  // then the normal handshake.
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    tmo_hit    = 1'b0;
    latch_wr   = 1'b0;
    if (!p7_en && (state_q != StWrPush)) begin
      fifo_flush = 1'b1;
      state_d    = StIdle;
    end else if (tmo_counting && (tmo_cnt_q == TMO_LAST)) begin
      tmo_hit = 1'b1;
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (p7_mode) begin
            state_d = StWrWait;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = StRdPresent;
          end
        end
        StRdPresent: begin
          if (!p7_rdc_n) begin
            state_d = StRdRelease;
          end
        end
        StRdRelease: begin
          if (p7_rdc_n) begin
            state_d = StIdle;
          end
        end
        StWrWait: begin
          if (!p7_wra_n) begin
            latch_wr = 1'b1;
            state_d  = StWrPush;
          end else if (!p7_mode) begin
            state_d = StIdle;
          end
        end
        StWrPush: begin
          if (tx_ready) begin
            state_d = StWrAck;
          end
        end
        StWrAck: begin
          if (p7_wra_n) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Timeout counter: cleared on every state change, saturating while it counts.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (tmo_counting && (tmo_cnt_q != '1)) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  // FSM state and timeout counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Data registers: read byte captured on pop, write byte captured on p7.2 fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rd_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      if (fifo_pop) begin
        host_rd_q <= fifo_rd_data;
      end
      if (latch_wr) begin
        tx_data_q <= mcu_wr_data;
      end
      tx_valid_q <= (state_d == StWrPush);
    end
  end

  // Status flags registered from the next state so p6 follows p7 by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rda_n_q  <= 1'b1;
      wack_n_q <= 1'b1;
      tmo_q    <= 1'b0;
    end else begin
      rda_n_q  <= (state_d != StRdPresent);
      wack_n_q <= (state_d != StWrAck);
      if (fifo_flush) begin
        tmo_q <= 1'b0;
      end else if (tmo_hit) begin
        tmo_q <= 1'b1;
      end
    end
  end

  assign host_rd_data = host_rd_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign p6_status    = pack_p6(rda_n_q, fifo_full, tmo_q, wack_n_q);

endmodule

// File: tb/tb_mcu_link_ctrl.sv
// Directed self-checking bench for mcu_link_ctrl (depth 4, 100-cycle timeout).
module tb_mcu_link_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [3:0] p7_ctrl = 4'b1110;
  logic [7:0] mcu_wr_data = '0;
  logic [7:0] host_rd_data;
  logic [3:0] p6_status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcu_link_ctrl #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .p7_ctrl      (p7_ctrl),
    .mcu_wr_data  (mcu_wr_data),
    .host_rd_data (host_rd_data),
    .p6_status    (p6_status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #23;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready);
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid);
    end
    checks++;
    if (tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data);
    end
    checks++;
    if (host_rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_host_rd_data: got %h want 00", host_rd_data);
    end
    checks++;
    if (p6_status !== 4'b1001) begin
      errors++; $display("FAIL reset_p6: got %b want 1001", p6_status);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (p6_status !== 4'b1001) begin
      errors++; $display("FAIL idle_p6_after_reset: got %b want 1001", p6_status);
    end
  endtask

  task automatic test_read_path();
    logic [7:0] exp_bytes [4];
    exp_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    p7_ctrl = 4'b1111;
    tick();
    for (int i = 0; i < 4; i++) begin
      rx_data  = exp_bytes[i];
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    p7_ctrl = 4'b1110;
    tick();  // WR_WAIT -> IDLE
    tick();  // IDLE pops -> RD_PRESENT
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (host_rd_data !== exp_bytes[i]) begin
        errors++; $display("FAIL rd_byte%0d: got %h want %h", i, host_rd_data, exp_bytes[i]);
      end
      checks++;
      if (p6_status[0] !== 1'b0) begin
        errors++; $display("FAIL rd_avail%0d: got %b want 0", i, p6_status[0]);
      end
      p7_ctrl = 4'b1100;
      tick();
      checks++;
      if (p6_status[0] !== 1'b1) begin
        errors++; $display("FAIL rd_release%0d: got %b want 1", i, p6_status[0]);
      end
      checks++;
      if (host_rd_data !== exp_bytes[i]) begin
        errors++; $display("FAIL rd_hold%0d: got %h want %h", i, host_rd_data, exp_bytes[i]);
      end
      p7_ctrl = 4'b1110;
      tick();
      tick();
    end
    checks++;
    if (p6_status !== 4'b1001) begin
      errors++; $display("FAIL rd_end_p6: got %b want 1001", p6_status);
    end
  endtask

  task automatic test_write_path();
    mcu_wr_data = 8'h44;
    p7_ctrl = 4'b1111;
    tick();  // IDLE -> WR_WAIT
    p7_ctrl = 4'b1011;
    tick();  // latch -> WR_PUSH
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h44) begin
      errors++; $display("FAIL wr_push: got valid %b data %h want 1 44", tx_valid, tx_data);
    end
    mcu_wr_data = 8'h99;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (p6_status[3] !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h44) begin
        errors++;
        $display("FAIL wr_hold%0d: got wack_n %b valid %b data %h want 1 1 44",
                 i, p6_status[3], tx_valid, tx_data);
      end
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    checks++;
    if (p6_status !== 4'b0001 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL wr_ack: got p6 %b valid %b want 0001 0", p6_status, tx_valid);
    end
    p7_ctrl = 4'b1111;
    tick();
    checks++;
    if (p6_status[3] !== 1'b1) begin
      errors++; $display("FAIL wr_ack_release: got %b want 1", p6_status[3]);
    end
    p7_ctrl = 4'b1110;
    tick();
    tick();
    checks++;
    if (p6_status !== 4'b1001 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL wr_end: got p6 %b valid %b want 1001 0", p6_status, tx_valid);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    p7_ctrl = 4'b1111;
    tick();
    for (int i = 0; i < 4; i++) begin
      rx_data  = bytes[i];
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("FAIL full_rx_ready: got %b want 0", rx_ready);
    end
    checks++;
    if (p6_status !== 4'b1011) begin
      errors++; $display("FAIL full_p6: got %b want 1011", p6_status);
    end
    // Fifth byte offered while full must be dropped.
    rx_data  = bytes[4];
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    p7_ctrl = 4'b1110;
    tick();
    tick();
    checks++;
    if (p6_status !== 4'b1000 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL full_after_pop: got p6 %b rdy %b want 1000 1", p6_status, rx_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (host_rd_data !== bytes[i]) begin
        errors++; $display("FAIL full_rd%0d: got %h want %h", i, host_rd_data, bytes[i]);
      end
      p7_ctrl = 4'b1100;
      tick();
      p7_ctrl = 4'b1110;
      tick();
      tick();
    end
    checks++;
    if (p6_status !== 4'b1001 || host_rd_data !== 8'h44) begin
      errors++; $display("FAIL full_drop: got p6 %b data %h want 1001 44", p6_status, host_rd_data);
    end
  endtask

  task automatic test_timeout();
    p7_ctrl = 4'b1111;
    tick();
    rx_data  = 8'hA1;
    rx_valid = 1'b1;
    tick();
    rx_data  = 8'hA2;
    tick();
    rx_valid = 1'b0;
    p7_ctrl = 4'b1110;
    tick();
    tick();  // RD_PRESENT entered, A1 presented
    for (int i = 0; i < 99; i++) begin
      tick();
    end
    checks++;
    if (p6_status !== 4'b1000) begin
      errors++; $display("FAIL tmo_before: got %b want 1000", p6_status);
    end
    tick();
    checks++;
    if (p6_status !== 4'b1101) begin
      errors++; $display("FAIL tmo_hit: got %b want 1101", p6_status);
    end
    tick();
    checks++;
    if (p6_status !== 4'b1100 || host_rd_data !== 8'hA2) begin
      errors++; $display("FAIL tmo_next: got p6 %b data %h want 1100 a2", p6_status, host_rd_data);
    end
    rx_data  = 8'hA3;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    p7_ctrl = 4'b0110;
    tick();
    checks++;
    if (p6_status !== 4'b1001) begin
      errors++; $display("FAIL tmo_flush: got %b want 1001", p6_status);
    end
    p7_ctrl = 4'b1110;
    tick();
    tick();
    checks++;
    if (p6_status !== 4'b1001 || host_rd_data !== 8'hA2) begin
      errors++;
      $display("FAIL flush_empty: got p6 %b data %h want 1001 a2", p6_status, host_rd_data);
    end
  endtask

  task automatic test_reset_mid_op();
    p7_ctrl = 4'b1111;
    tick();
    rx_data  = 8'hB1;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    p7_ctrl = 4'b1110;
    tick();
    tick();
    checks++;
    if (p6_status[0] !== 1'b0 || host_rd_data !== 8'hB1) begin
      errors++;
      $display("FAIL rst_rd_pre: got rda_n %b data %h want 0 b1", p6_status[0], host_rd_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (p6_status !== 4'b1001 || host_rd_data !== 8'h00 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_rd: got p6 %b data %h rdy %b want 1001 00 1",
               p6_status, host_rd_data, rx_ready);
    end
    #2 rst = 1'b0;
    tick();
    tick();
    checks++;
    if (p6_status !== 4'b1001) begin
      errors++; $display("FAIL rst_fifo_empty: got %b want 1001", p6_status);
    end
    mcu_wr_data = 8'h77;
    p7_ctrl = 4'b1111;
    tick();
    p7_ctrl = 4'b1011;
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin
      errors++; $display("FAIL rst_wr_pre: got valid %b data %h want 1 77", tx_valid, tx_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || p6_status !== 4'b1001) begin
      errors++;
      $display("FAIL rst_wr: got valid %b data %h p6 %b want 0 00 1001",
               tx_valid, tx_data, p6_status);
    end
    p7_ctrl = 4'b1110;
    #2 rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_path();
    test_write_path();
    test_fifo_full();
    test_timeout();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
